bram_ctrl: RTL and testbench

BRAM_CTRL -- requirements
Module: bram_ctrl

---
 rtl/bram_ctrl.sv | 101 ++++++++++
 tb/tb_bram_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ctrl.sv
// Single-outstanding request/response controller in front of a registered-output BRAM.
// Optional write acknowledge: define BRAM_CTRL_WACK_EN to return a response for writes.
module bram_ctrl #(
  parameter int unsigned LAT = 10,
  parameter int unsigned AW  = 13,
  parameter int unsigned DW  = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_a,
  output logic [DW-1:0] bram_di,
  input  logic [DW-1:0] bram_do,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StWait, StWdone, StResp} state_e;

  localparam logic [3:0] LatLast = 4'(LAT - 1);
  localparam logic [3:0] LatSat  = 4'(LAT);

  state_e     state_q;
  logic [3:0] cnt_q;

  // Ready is gated by reset so it reads 0 while RST_N is held low.
  assign req_ready = RST_N && (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_a    <= '0;
      bram_di   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            bram_en <= 1'b1;
            bram_we <= req_we;
            bram_a  <= req_addr;
            bram_di <= req_wdata;
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bram_we) begin
            // Write issue cycle is over; the BRAM has taken the data.
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            state_q <= StWdone;
`ifdef BRAM_CTRL_WACK_EN
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
`endif
          end else if (cnt_q == LatLast) begin
            rsp_rdata <= bram_do;
            rsp_valid <= 1'b1;
            bram_en   <= 1'b0;
            cnt_q     <= LatSat;
            state_q   <= StResp;
          end else if (cnt_q != LatSat) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StWdone: begin
`ifdef BRAM_CTRL_WACK_EN
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed self-checking bench for bram_ctrl: LAT=10 instance (a_*) and LAT=2 instance (b_*),
// each backed by a one-cycle registered-output BRAM model.
module tb_bram_ctrl;

  logic        CLK;
  logic        RST_N;
  int          total;
  int          bad;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [12:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic        bram_en, bram_we, busy;
  logic [12:0] bram_a;
  logic [31:0] bram_di, bram_do;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [12:0] b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic        b_bram_en, b_bram_we, b_busy;
  logic [12:0] b_bram_a;
  logic [31:0] b_bram_di, b_bram_do;

  logic [31:0] mem_a [8192];
  logic [31:0] mem_b [8192];

  bram_ctrl #(.LAT(10), .AW(13), .DW(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di),
    .bram_do(bram_do), .busy(busy)
  );

  bram_ctrl #(.LAT(2), .AW(13), .DW(32)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_a(b_bram_a), .bram_di(b_bram_di),
    .bram_do(b_bram_do), .busy(b_busy)
  );

  always_ff @(posedge CLK) begin
    if (bram_en) begin
      if (bram_we) mem_a[bram_a] <= bram_di;
      bram_do <= mem_a[bram_a];
    end else begin
      bram_do <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (b_bram_en) begin
      if (b_bram_we) mem_b[b_bram_a] <= b_bram_di;
      b_bram_do <= mem_b[b_bram_a];
    end else begin
      b_bram_do <= '0;
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) step();
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_a, bram_di, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h en=%b we=%b a=%h di=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_a, bram_di, busy);
    end
    RST_N = 1'b1;
    step();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || b_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b b_rdy=%b want 1 0 1", req_ready, busy, b_req_ready);
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h0005; req_wdata = 32'hDEADBEEF;
    step();  // E0
    total++;
    if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_a !== 13'h0005 || bram_di !== 32'hDEADBEEF
        || req_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_issue: got en=%b we=%b a=%h di=%h rdy=%b busy=%b want 1 1 0005 deadbeef 0 1",
               bram_en, bram_we, bram_a, bram_di, req_ready, busy);
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = 13'h0AAA; req_wdata = 32'h0;
    step();  // E0+1
    total++;
    if (bram_en !== 1'b0 || bram_we !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL write_drop: got en=%b we=%b rdy=%b want 0 0 0", bram_en, bram_we, req_ready);
    end
`ifdef BRAM_CTRL_WACK_EN
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL write_ack: got rv=%b rd=%h want 1 00000000", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_noack: got rv=%b want 0", rsp_valid);
    end
    step();  // E0+2
`endif
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_idle: got rdy=%b busy=%b rv=%b want 1 0 0", req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_read_hold();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0005; req_wdata = 32'h0;
    step();  // E0
    req_valid = 1'b0; req_addr = 13'h1234; req_we = 1'b1;
    total++;
    if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_a !== 13'h0005) begin
      bad++;
      $display("FAIL read_issue: got en=%b we=%b a=%h want 1 0 0005", bram_en, bram_we, bram_a);
    end
    for (int k = 1; k < 10; k++) begin
      step();
      total++;
      if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_a !== 13'h0005 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL read_wait_%0d: got en=%b we=%b a=%h rv=%b want 1 0 0005 0",
                 k, bram_en, bram_we, bram_a, rsp_valid);
      end
    end
    step();  // E0+10
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || bram_en !== 1'b0) begin
      bad++;
      $display("FAIL read_capture: got rv=%b rd=%h en=%b want 1 deadbeef 0",
               rsp_valid, rsp_rdata, bram_en);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0
          || bram_en !== 1'b0) begin
        bad++;
        $display("FAIL read_hold_%0d: got rv=%b rd=%h rdy=%b en=%b want 1 deadbeef 0 0",
                 k, rsp_valid, rsp_rdata, req_ready, bram_en);
      end
    end
    rsp_ready = 1'b1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL read_hs_cycle_rdy: got %b want 0", req_ready);
    end
    step();
    rsp_ready = 1'b0;
    req_we = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL read_done: got rv=%b rdy=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen_rsp;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0005;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    RST_N = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_a, bram_di, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_wait: got rdy=%b rv=%b rd=%h en=%b we=%b a=%h di=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_a, bram_di, busy);
    end
    repeat (3) step();
    total++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: got rdy=%b busy=%b rv=%b want 0 0 0", req_ready, busy, rsp_valid);
    end
    RST_N = 1'b1;
    step();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_release: got rdy=%b busy=%b want 1 0", req_ready, busy);
    end
    seen_rsp = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rsp_valid === 1'b1) seen_rsp++;
    end
    total++;
    if (seen_rsp != 0) begin
      bad++;
      $display("FAIL reset_abandon: got %0d rsp_valid cycles want 0", seen_rsp);
    end
  endtask

  task automatic test_back_to_back();
    int acc_at;
    int we_cycles;
    int waited;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h1FFF; req_wdata = 32'h12345678;
    step();  // E0 write
    req_we = 1'b0; req_wdata = 32'hFFFF0000;
    acc_at = 0;
    we_cycles = 0;
    for (int k = 1; k <= 8 && acc_at == 0; k++) begin
      step();
      if (bram_we === 1'b1) we_cycles++;
      if (bram_en === 1'b1 && bram_we === 1'b0 && bram_a === 13'h1FFF) acc_at = k;
    end
    req_valid = 1'b0;
    total++;
    if (acc_at != 3 || we_cycles != 0) begin
      bad++;
      $display("FAIL b2b_accept: got accept at E0+%0d extra_we=%0d want E0+3 0", acc_at, we_cycles);
    end
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || waited != 10) begin
      bad++;
      $display("FAIL b2b_read: got rv=%b rd=%h after %0d cycles want 1 12345678 after 10",
               rsp_valid, rsp_rdata, waited);
    end
    step();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle: got rv=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_lat2();
    int waited;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 13'h0000; b_req_wdata = 32'hA5A5A5A5;
    step();
    b_req_valid = 1'b0; b_req_we = 1'b0;
    waited = 0;
    while (b_req_ready !== 1'b1 && waited < 6) begin
      step();
      waited++;
    end
    b_rsp_ready = 1'b0;
    b_req_valid = 1'b1;
    step();  // E0
    b_req_valid = 1'b0;
    total++;
    if (b_bram_en !== 1'b1 || b_bram_we !== 1'b0 || b_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat2_issue: got en=%b we=%b rv=%b want 1 0 0", b_bram_en, b_bram_we, b_rsp_valid);
    end
    step();  // E0+1
    total++;
    if (b_rsp_valid !== 1'b0 || b_bram_en !== 1'b1) begin
      bad++;
      $display("FAIL lat2_wait: got rv=%b en=%b want 0 1", b_rsp_valid, b_bram_en);
    end
    step();  // E0+2
    total++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hA5A5A5A5 || b_bram_en !== 1'b0) begin
      bad++;
      $display("FAIL lat2_capture: got rv=%b rd=%h en=%b want 1 a5a5a5a5 0",
               b_rsp_valid, b_rsp_rdata, b_bram_en);
    end
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    total++;
    if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL lat2_done: got rv=%b rdy=%b busy=%b want 0 1 0", b_rsp_valid, b_req_ready, b_busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    RST_N = 1'b0;
    test_reset();
    test_write();
    test_read_hold();
    test_reset_mid_wait();
    test_back_to_back();
    test_lat2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
